// File: rtl/cpu_run_pkg.sv
// Shared types and constants for the CPU run-control monitor.
package cpu_run_pkg;

    // Run-control FSM states; the encoding is visible on the monitor's state port.
    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_HOLD         = 3'd1,
        ST_RUN          = 3'd2,
        ST_DONE_PASS    = 3'd3,
        ST_DONE_FAIL    = 3'd4,
        ST_DONE_TIMEOUT = 3'd5,
        ST_DONE_HANG    = 3'd6
    } run_state_t;

    // ecall: the program's way of saying it has finished.
    localparam logic [31:0] HALT_ECALL = 32'h0000_0073;

    // RISC-V ABI register indices.
    localparam int unsigned ABI_ZERO = 0;
    localparam int unsigned ABI_RA   = 1;
    localparam int unsigned ABI_SP   = 2;
    localparam int unsigned ABI_A0   = 10;
    localparam int unsigned ABI_A1   = 11;

    function automatic logic is_done_state(input run_state_t s);
        return (s == ST_DONE_PASS) || (s == ST_DONE_FAIL) ||
               (s == ST_DONE_TIMEOUT) || (s == ST_DONE_HANG);
    endfunction

endpackage

// File: rtl/run_reg_mirror.sv
// Architectural register-file mirror: one write port, two combinational read
// ports, x0 hardwired to zero, bulk clear for starting a fresh run.
module run_reg_mirror #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned AW       = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr_a,
    output logic [XLEN-1:0] rdata_a,
    input  logic [AW-1:0]   raddr_b,
    output logic [XLEN-1:0] rdata_b
);

    logic [XLEN-1:0] regs [NUM_REGS];

    // Register array: cleared on reset or clear, x0 never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (clear) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    // Read ports: x0 forced to zero regardless of array contents.
    always_comb begin
        rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
        rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];
    end

endmodule

// File: rtl/cpu_run_monitor.sv
// Run-control and retirement monitor: sequences CPU reset, mirrors the
// register file, counts cycles/retirements and decides pass/fail/timeout/hang.
module cpu_run_monitor
    import cpu_run_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned NUM_REGS     = 32,
    parameter int unsigned RESET_CYCLES = 4,
    parameter int unsigned MAX_CYCLES   = 100000,
    parameter int unsigned HANG_LIMIT   = 16,
    parameter logic [31:0] HALT_INSTR   = HALT_ECALL,
    parameter int unsigned RESULT_REG   = ABI_A0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    output logic                        cpu_reset,
    input  logic                        wb_valid,
    input  logic [$clog2(NUM_REGS)-1:0] wb_rd,
    input  logic [XLEN-1:0]             wb_data,
    input  logic                        ret_valid,
    input  logic [XLEN-1:0]             ret_pc,
    input  logic [31:0]                 ret_instr,
    input  logic [$clog2(NUM_REGS)-1:0] dbg_addr,
    output logic [XLEN-1:0]             dbg_data,
    output logic [31:0]                 cycle_count,
    output logic [31:0]                 retire_count,
    output logic [2:0]                  state,
    output logic                        done,
    output logic                        pass
);

    localparam int unsigned AW        = $clog2(NUM_REGS);
    localparam logic [AW-1:0] RES_IDX = AW'(RESULT_REG);
    localparam logic [31:0] HOLD_LAST = 32'(RESET_CYCLES - 1);
    localparam logic [31:0] CNT_MAX   = '1;

    run_state_t      state_q, state_d;
    logic [31:0]     hold_cnt, cycle_q, retire_q, hang_len, hang_len_d, cycle_inc;
    logic [XLEN-1:0] hang_pc, result_mirror, result_val;
    logic            in_run, enter_hold, mirror_we, same_pc;
    logic            halt_hit, hang_hit, timeout_hit;

    run_reg_mirror #(
        .XLEN     (XLEN),
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_mirror (
        .clk     (clk),
        .rst_n   (reset),
        .clear   (enter_hold),
        .we      (mirror_we),
        .waddr   (wb_rd),
        .wdata   (wb_data),
        .raddr_a (dbg_addr),
        .rdata_a (dbg_data),
        .raddr_b (RES_IDX),
        .rdata_b (result_mirror)
    );

    // Per-cycle decision terms for the RUN state.
    always_comb begin
        in_run      = (state_q == ST_RUN);
        enter_hold  = start && ((state_q == ST_IDLE) || is_done_state(state_q));
        mirror_we   = in_run && wb_valid && (wb_rd != '0);
        cycle_inc   = (cycle_q == CNT_MAX) ? cycle_q : cycle_q + 32'd1;
        same_pc     = (hang_len != '0) && (ret_pc == hang_pc);
        hang_len_d  = same_pc ? ((hang_len == CNT_MAX) ? hang_len : hang_len + 32'd1) : 32'd1;
        // Same-cycle writeback to the result register bypasses the mirror.
        result_val  = (wb_valid && (wb_rd == RES_IDX) && (wb_rd != '0)) ? wb_data : result_mirror;
        halt_hit    = ret_valid && (ret_instr == HALT_INSTR);
        hang_hit    = ret_valid && (hang_len_d >= HANG_LIMIT);
        timeout_hit = (cycle_inc >= MAX_CYCLES);
    end

    // Next-state logic with halt > hang > timeout priority.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE_PASS, ST_DONE_FAIL, ST_DONE_TIMEOUT, ST_DONE_HANG: begin
                if (start) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (hold_cnt >= HOLD_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (halt_hit)         state_d = (result_val == '0) ? ST_DONE_PASS : ST_DONE_FAIL;
                else if (hang_hit)    state_d = ST_DONE_HANG;
                else if (timeout_hit) state_d = ST_DONE_TIMEOUT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register and registered CPU reset (high outside RUN).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cpu_reset <= 1'b1;
        end else begin
            state_q   <= state_d;
            cpu_reset <= (state_d != ST_RUN);
        end
    end

    // Hold timer, run counters and hang tracker; frozen outside HOLD/RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt <= '0;
            cycle_q  <= '0;
            retire_q <= '0;
            hang_len <= '0;
            hang_pc  <= '0;
        end else if (enter_hold) begin
            hold_cnt <= '0;
            cycle_q  <= '0;
            retire_q <= '0;
            hang_len <= '0;
            hang_pc  <= '0;
        end else if (state_q == ST_HOLD) begin
            hold_cnt <= hold_cnt + 32'd1;
        end else if (in_run) begin
            cycle_q <= cycle_inc;
            if (ret_valid) begin
                retire_q <= (retire_q == CNT_MAX) ? retire_q : retire_q + 32'd1;
                hang_len <= hang_len_d;
                hang_pc  <= ret_pc;
            end
        end
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        state        = state_q;
        done         = is_done_state(state_q);
        pass         = (state_q == ST_DONE_PASS);
        cycle_count  = cycle_q;
        retire_count = retire_q;
    end

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Scoreboard bench for cpu_run_monitor: each run pushes its expected terminal
// snapshot, and a monitor compares it when done rises.
module tb_cpu_run_monitor;

    logic        clk = 1'b0;
    logic        reset, start, cpu_reset;
    logic        wb_valid, ret_valid, done, pass;
    logic [4:0]  wb_rd, dbg_addr;
    logic [31:0] wb_data, ret_pc, ret_instr, dbg_data, cycle_count, retire_count;
    logic [2:0]  state;

    typedef struct {
        string       name;
        logic [2:0]  st;
        logic        ps;
        logic [31:0] cyc;
        logic [31:0] ret;
        logic [31:0] dbg;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic done_q = 1'b0;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] ECALL = 32'h0000_0073;

    cpu_run_monitor #(
        .XLEN         (32),
        .NUM_REGS     (32),
        .RESET_CYCLES (4),
        .MAX_CYCLES   (50),
        .HANG_LIMIT   (4),
        .HALT_INSTR   (ECALL),
        .RESULT_REG   (10)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cpu_reset    (cpu_reset),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .ret_valid    (ret_valid),
        .ret_pc       (ret_pc),
        .ret_instr    (ret_instr),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data),
        .cycle_count  (cycle_count),
        .retire_count (retire_count),
        .state        (state),
        .done         (done),
        .pass         (pass)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare the oldest expected snapshot whenever done rises.
    always @(negedge clk) begin
        if (done && !done_q) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got state %0d expected no terminal state", state);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.name, "_state"},  {29'd0, state}, {29'd0, e.st});
                chk({e.name, "_pass"},   {31'd0, pass},  {31'd0, e.ps});
                chk({e.name, "_cycles"}, cycle_count,    e.cyc);
                chk({e.name, "_retire"}, retire_count,   e.ret);
                chk({e.name, "_dbg"},    dbg_data,       e.dbg);
            end
        end
        done_q = done;
    end

    task automatic idle_inputs();
        start = 1'b0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        ret_valid = 1'b0; ret_pc = '0; ret_instr = '0;
    endtask

    task automatic run_cycle(input logic wv, input logic [4:0] rd, input logic [31:0] wd,
                             input logic rv, input logic [31:0] pc, input logic [31:0] ins,
                             input logic st);
        wb_valid = wv; wb_rd = rd; wb_data = wd;
        ret_valid = rv; ret_pc = pc; ret_instr = ins; start = st;
        @(posedge clk); #1;
        idle_inputs();
    endtask

    // Pulse start and count how many sampled cycles cpu_reset stays high.
    task automatic start_and_hold(output int n);
        n = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!cpu_reset) break;
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done(input int maxc, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_wait: got done=0 expected done=1 within %0d cycles", name, maxc);
        end
        @(negedge clk); #1;
    endtask

    initial begin
        int n;
        exp_t e;
        idle_inputs();
        dbg_addr = '0;
        reset = 1'b0;
        #12;
        chk("rst_state",     {29'd0, state},     32'd0);
        chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("rst_done",      {31'd0, done},      32'd0);
        chk("rst_pass",      {31'd0, pass},      32'd0);
        chk("rst_cycles",    cycle_count,        32'd0);
        chk("rst_retire",    retire_count,       32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Pass program with reset-sequencing measurement.
        dbg_addr = 5'd5;
        e = '{"pass_prog", 3'd3, 1'b1, 32'd3, 32'd3, 32'd7};
        exp_q.push_back(e);
        start_and_hold(n);
        chk("hold_cycles", n, 32'd4);
        chk("hold_to_run", {29'd0, state}, 32'd2);
        run_cycle(1'b1, 5'd10, 32'd0, 1'b1, 32'h0, NOP,   1'b0);
        run_cycle(1'b1, 5'd5,  32'd7, 1'b1, 32'h4, NOP,   1'b0);
        run_cycle(1'b0, 5'd0,  32'd0, 1'b1, 32'h8, ECALL, 1'b0);
        wait_done(5, "pass_prog");
        chk("done_cpu_reset", {31'd0, cpu_reset}, 32'd1);

        // Second start re-zeroes; fail via same-cycle writeback bypass.
        start_and_hold(n);
        chk("restart_cycles", cycle_count,  32'd0);
        chk("restart_retire", retire_count, 32'd0);
        chk("restart_mirror", dbg_data,     32'd0);
        dbg_addr = 5'd10;
        e = '{"fail_bypass", 3'd4, 1'b0, 32'd2, 32'd2, 32'd5};
        exp_q.push_back(e);
        run_cycle(1'b1, 5'd0,  32'hDEAD, 1'b1, 32'h0, NOP,   1'b0);
        run_cycle(1'b1, 5'd10, 32'd5,    1'b1, 32'h4, ECALL, 1'b0);
        wait_done(5, "fail_bypass");
        dbg_addr = 5'd0;
        #1;
        chk("x0_reads_zero", dbg_data, 32'd0);

        // Hang: an interleaved 0x44 restarts the run length; start in RUN is ignored.
        dbg_addr = 5'd10;
        e = '{"hang", 3'd6, 1'b0, 32'd8, 32'd8, 32'd0};
        exp_q.push_back(e);
        start_and_hold(n);
        run_cycle(1'b0, 5'd0, 32'd0, 1'b1, 32'h40, NOP, 1'b1);
        run_cycle(1'b0, 5'd0, 32'd0, 1'b1, 32'h40, NOP, 1'b0);
        run_cycle(1'b0, 5'd0, 32'd0, 1'b1, 32'h40, NOP, 1'b0);
        run_cycle(1'b0, 5'd0, 32'd0, 1'b1, 32'h44, NOP, 1'b0);
        run_cycle(1'b0, 5'd0, 32'd0, 1'b1, 32'h40, NOP, 1'b0);
        run_cycle(1'b0, 5'd0, 32'd0, 1'b1, 32'h40, NOP, 1'b0);
        run_cycle(1'b0, 5'd0, 32'd0, 1'b1, 32'h40, NOP, 1'b0);
        chk("no_early_hang", {31'd0, done}, 32'd0);
        run_cycle(1'b0, 5'd0, 32'd0, 1'b1, 32'h40, NOP, 1'b0);
        wait_done(5, "hang");

        // Timeout after exactly MAX_CYCLES RUN cycles.
        e = '{"timeout", 3'd5, 1'b0, 32'd50, 32'd0, 32'd0};
        exp_q.push_back(e);
        start_and_hold(n);
        wait_done(60, "timeout");

        // Asynchronous reset mid-RUN, start ignored while reset is low.
        start_and_hold(n);
        run_cycle(1'b0, 5'd0, 32'd0, 1'b1, 32'h0, NOP, 1'b0);
        @(negedge clk); #1;
        reset = 1'b0;
        #1;
        chk("async_state",     {29'd0, state},     32'd0);
        chk("async_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("async_cycles",    cycle_count,        32'd0);
        start = 1'b1;
        @(posedge clk); #1;
        chk("start_in_reset", {29'd0, state}, 32'd0);
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_reset", {29'd0, state}, 32'd0);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
